// File: rtl/truth_table_scanner_if.sv
// Bus between the truth-table scanner and whoever drives it.
// The slave side is the scanner. The master side supplies start, the expected
// mask and the function-under-test response, and receives the rest.
interface truth_table_scanner_if #(
    parameter int N_VARS = 3
);
    localparam int N_COMB = 1 << N_VARS;

    logic                start;
    logic [N_COMB-1:0]   expected;
    logic [N_VARS-1:0]   vars;
    logic                s_in;
    logic                busy;
    logic                done;
    logic [N_COMB-1:0]   truth;
    logic [N_VARS:0]     ones;
    logic                match;

    modport master (
        output start, expected, s_in,
        input  vars, busy, done, truth, ones, match
    );

    modport slave (
        input  start, expected, s_in,
        output vars, busy, done, truth, ones, match
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks vars through 0 .. 2^N_VARS-1 and holds each value
// for SETTLE wait cycles plus one sample cycle. It records the function
// response into a minterm mask, counts the ones, and compares the mask against
// an expected mask that is latched at start.
module truth_table_scanner #(
    parameter int N_VARS = 3,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_scanner_if.slave  bus
);
    localparam int N_COMB = 1 << N_VARS;
    localparam int CW     = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    localparam logic [CW-1:0]     SETTLE_C = CW'(SETTLE);
    localparam logic [N_VARS-1:0] LAST     = {N_VARS{1'b1}};

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    // With no settle time, each combination goes straight to its sample cycle.
    localparam state_t AFTER_LOAD = (SETTLE == 0) ? SAMPLE : WAIT;

    state_t              state_q, state_d;
    logic [N_VARS-1:0]   vars_q, vars_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_COMB-1:0]   truth_q, truth_d;
    logic [N_COMB-1:0]   exp_q, exp_d;
    logic [N_VARS:0]     ones_q, ones_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                match_q, match_d;

    // State and result registers. A reset abandons any scan in progress.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vars_q  <= '0;
            cnt_q   <= '0;
            truth_q <= '0;
            exp_q   <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vars_q  <= vars_d;
            cnt_q   <= cnt_d;
            truth_q <= truth_d;
            exp_q   <= exp_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    // Next-state and datapath updates. Start is honoured only in IDLE or DONE.
    // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        vars_d  = vars_q;
        cnt_d   = cnt_q;
        truth_d = truth_q;
        exp_d   = exp_q;
        ones_d  = ones_q;
        busy_d  = busy_q;
        done_d  = done_q;
        match_d = match_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    exp_d   = bus.expected;
                    vars_d  = '0;
                    truth_d = '0;
                    ones_d  = '0;
                    match_d = 1'b0;
                    cnt_d   = SETTLE_C;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = AFTER_LOAD;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                truth_d[vars_q] = bus.s_in;
                ones_d          = ones_q + {{N_VARS{1'b0}}, bus.s_in};
                if (vars_q != LAST) begin
                    vars_d  = vars_q + 1'b1;
                    cnt_d   = SETTLE_C;
                    state_d = AFTER_LOAD;
                end else begin
                    vars_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    match_d = (truth_d == exp_q);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.vars  = vars_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.truth = truth_q;
    assign bus.ones  = ones_q;
    assign bus.match = match_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner. It instantiates one scanner with SETTLE=1
// (index 0) and one with SETTLE=0 (index 1). Both share the clock and reset.
// A cycle-count model predicts every output on every falling edge.
module tb_truth_table_scanner;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    truth_table_scanner_if #(.N_VARS(3)) if_a ();
    truth_table_scanner_if #(.N_VARS(3)) if_b ();

    truth_table_scanner #(.N_VARS(3), .SETTLE(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    truth_table_scanner #(.N_VARS(3), .SETTLE(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    // Stimulus per instance. fut_v is the function-under-test as a truth mask.
    logic       start_v [2];
    logic [7:0] exp_v   [2];
    logic [7:0] fut_v   [2];

    assign if_a.start    = start_v[0];
    assign if_a.expected = exp_v[0];
    assign if_a.s_in     = fut_v[0][if_a.vars];
    assign if_b.start    = start_v[1];
    assign if_b.expected = exp_v[1];
    assign if_b.s_in     = fut_v[1][if_b.vars];

    // Observed outputs, packed as {vars, busy, done, truth, ones, match}.
    logic [17:0] dut_t   [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [7:0]  truth_w [2];
    logic [3:0]  ones_w  [2];
    logic        match_w [2];

    assign dut_t[0]   = {if_a.vars, if_a.busy, if_a.done, if_a.truth, if_a.ones, if_a.match};
    assign dut_t[1]   = {if_b.vars, if_b.busy, if_b.done, if_b.truth, if_b.ones, if_b.match};
    assign busy_w[0]  = if_a.busy;   assign busy_w[1]  = if_b.busy;
    assign done_w[0]  = if_a.done;   assign done_w[1]  = if_b.done;
    assign truth_w[0] = if_a.truth;  assign truth_w[1] = if_b.truth;
    assign ones_w[0]  = if_a.ones;   assign ones_w[1]  = if_b.ones;
    assign match_w[0] = if_a.match;  assign match_w[1] = if_b.match;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Model state: whether a scan has been accepted since reset, the number of
    // edges since the accepting edge, and the function and expected mask at that edge.
    bit         act [2];
    int         m   [2];
    logic [7:0] mf  [2];
    logic [7:0] me  [2];

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int total_of(input int i);
        return 8 * (settle_of(i) + 1);
    endfunction

    // Every combination takes SETTLE+1 edges. After m edges, m/(SETTLE+1) bits are known.
    function automatic logic [17:0] predict(input int i);
        int         samp;
        logic [7:0] t;
        logic [7:0] lowmask;
        if (!act[i]) return '0;
        if (m[i] >= total_of(i))
            return {3'd0, 1'b0, 1'b1, mf[i], 4'($countones(mf[i])), mf[i] == me[i]};
        samp    = m[i] / (settle_of(i) + 1);
        lowmask = 8'((1 << samp) - 1);
        t       = mf[i] & lowmask;
        return {3'(samp), 1'b1, 1'b0, t, 4'($countones(t)), 1'b0};
    endfunction

    // Advance the model on every rising edge; reset clears it at once.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                act[i] = 1'b0;
                m[i]   = 0;
                mf[i]  = '0;
                me[i]  = '0;
            end else if (start_v[i] && (!act[i] || m[i] >= total_of(i))) begin
                act[i] = 1'b1;
                m[i]   = 0;
                mf[i]  = fut_v[i];
                me[i]  = exp_v[i];
            end else if (act[i] && m[i] < total_of(i)) begin
                m[i] = m[i] + 1;
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        check("cycle_settle1", 32'(dut_t[0]), 32'(predict(0)));
        check("cycle_settle0", 32'(dut_t[1]), 32'(predict(1)));
    end

    // Run one scan on instance i. Optionally pulse start again after pulse_at edges,
    // with a different expected value on the bus. Returns the edges from accept to done.
    task automatic run_scan(input int i, input logic [7:0] f, input logic [7:0] e,
                            input int pulse_at, output int lat);
        int k;
        bit got;
        @(negedge clk);
        fut_v[i]   = f;
        exp_v[i]   = e;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        check("accept_clears", {busy_w[i], done_w[i], truth_w[i], ones_w[i], match_w[i]},
              {1'b1, 1'b0, 8'h00, 4'h0, 1'b0});
        k   = 0;
        got = 1'b0;
        while (k < 100 && !got) begin
            @(negedge clk);
            start_v[i] = (k == pulse_at);
            if (k == pulse_at) exp_v[i] = ~e;
            @(posedge clk);
            #1;
            k++;
            got = done_w[i];
        end
        start_v[i] = 1'b0;
        if (!got) check("scan_timeout", 32'd0, 32'd1);
        lat = k;
    endtask

    initial begin
        int         lat;
        bit         seen;
        logic [7:0] spec_f;
        logic [7:0] f;
        logic [7:0] e;
        int         i;
        int         pulse;

        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            start_v[j] = 1'b0;
            exp_v[j]   = '0;
            fut_v[j]   = '0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset: all outputs stay zero.
        repeat (10) @(negedge clk);
        check("idle_a", 32'(dut_t[0]), 32'd0);
        check("idle_b", 32'(dut_t[1]), 32'd0);

        // s = (x|y) & ~(~y|z) with x as the index MSB.
        spec_f = '0;
        for (int c = 0; c < 8; c++) begin
            logic x, y, z;
            x = c[2]; y = c[1]; z = c[0];
            spec_f[c] = (x | y) & ~(~y | z);
        end
        check("spec_mask", 32'(spec_f), 32'h44);

        run_scan(0, spec_f, 8'h44, -1, lat);
        check("spec_latency", lat, 16);
        check("spec_truth", 32'(truth_w[0]), 32'h44);
        check("spec_ones", 32'(ones_w[0]), 32'd2);
        check("spec_match", 32'(match_w[0]), 32'd1);

        run_scan(0, spec_f, 8'h45, -1, lat);
        check("mism_truth", 32'(truth_w[0]), 32'h44);
        check("mism_ones", 32'(ones_w[0]), 32'd2);
        check("mism_match", 32'(match_w[0]), 32'd0);

        // A start pulse in cycle 5 is ignored, and the latched expected value is kept.
        run_scan(0, spec_f, 8'h44, 4, lat);
        check("busy_start_latency", lat, 16);
        check("busy_start_match", 32'(match_w[0]), 32'd1);

        // Reset in the middle of a scan.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_a", 32'(dut_t[0]), 32'd0);
        check("async_reset_b", 32'(dut_t[1]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done_w[0]) seen = 1'b1;
        end
        check("no_done_after_reset", 32'(seen), 32'd0);
        run_scan(0, spec_f, 8'h44, -1, lat);
        check("post_reset_latency", lat, 16);
        check("post_reset_match", 32'(match_w[0]), 32'd1);

        // SETTLE=0 instance with constant functions.
        run_scan(1, 8'hFF, 8'hFF, -1, lat);
        check("s0_latency", lat, 8);
        check("s0_truth_ff", 32'(truth_w[1]), 32'hFF);
        check("s0_ones_8", 32'(ones_w[1]), 32'h8);
        check("s0_match_ff", 32'(match_w[1]), 32'd1);
        run_scan(1, 8'h00, 8'h00, -1, lat);
        check("s0_truth_00", 32'(truth_w[1]), 32'h00);
        check("s0_ones_0", 32'(ones_w[1]), 32'd0);

        // Random functions and expected masks on both instances.
        for (int n = 0; n < 24; n++) begin
            i     = int'($urandom_range(0, 1));
            f     = 8'($urandom);
            e     = ($urandom_range(0, 1) == 1) ? f : 8'($urandom);
            pulse = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
            run_scan(i, f, e, pulse, lat);
            check("rand_latency", lat, (i == 0) ? 16 : 8);
            check("rand_truth", 32'(truth_w[i]), 32'(f));
            check("rand_ones", 32'(ones_w[i]), 32'($countones(f)));
            check("rand_match", 32'(match_w[i]), 32'(f == e));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
